// File: rtl/alu_exec.sv
// alu_exec: instruction sequencer around an external ALU, with memory operand read and result write-back phases.
// Define RMW_DUMMY_WRITE_EN to write the unmodified operand before the result on read-modify-write memory ops.
module alu_exec #(
  parameter logic [7:0] P_INIT = 8'h34
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [7:0]  opcode,
  input  logic [3:0]  alu_mode,
  input  logic [1:0]  a_sel,
  input  logic [1:0]  b_sel,
  input  logic [2:0]  dst_sel,
  input  logic        flag_en,
  input  logic [15:0] addr,
  output logic        busy,
  output logic        done,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic [3:0]  alu_op,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [7:0]  alu_p,
  output logic [7:0]  alu_opc,
  input  logic [7:0]  alu_r,
  input  logic [7:0]  alu_f,
  output logic [7:0]  reg_a,
  output logic [7:0]  reg_p
);
  typedef enum logic [2:0] {IDLE, READ, EXEC, WRITE_OLD, WRITE} state_t;
  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_opc;
  logic [3:0]  r_mode;
  logic [1:0]  r_asel;
  logic [1:0]  r_bsel;
  logic [2:0]  r_dst;
  logic        r_fen;
  logic [15:0] r_addr;
  logic [7:0]  r_opnd;
  logic [7:0]  r_res;
  logic [7:0]  r_a;
  logic [7:0]  r_x;
  logic [7:0]  r_y;
  logic [7:0]  r_p;
  logic        r_done;
  logic        w_dummy;
`ifdef RMW_DUMMY_WRITE_EN
  assign w_dummy = r_bsel == 2'd3;
`else
  assign w_dummy = 1'b0;
`endif
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      w_next = start ? ((b_sel == 2'd3) ? READ : EXEC) : IDLE;
      READ:      w_next = mem_ack ? EXEC : READ;
      EXEC:      w_next = (r_dst != 3'd3) ? IDLE : (w_dummy ? WRITE_OLD : WRITE);
      WRITE_OLD: w_next = mem_ack ? WRITE : WRITE_OLD;
      WRITE:     w_next = mem_ack ? IDLE : WRITE;
      default:   w_next = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_opc   <= '0;
      r_mode  <= '0;
      r_asel  <= '0;
      r_bsel  <= '0;
      r_dst   <= '0;
      r_fen   <= 1'b0;
      r_addr  <= '0;
      r_opnd  <= '0;
      r_res   <= '0;
      r_a     <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_p     <= P_INIT;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (r_state == EXEC && w_next == IDLE) || (r_state == WRITE && mem_ack);
      if (r_state == IDLE && start) begin
        r_opc  <= opcode;
        r_mode <= alu_mode;
        r_asel <= a_sel;
        r_bsel <= b_sel;
        r_dst  <= dst_sel;
        r_fen  <= flag_en;
        r_addr <= addr;
      end
      if (r_state == READ && mem_ack)
        r_opnd <= mem_rdata;
      if (r_state == EXEC) begin
        r_res <= alu_r;
        if (r_dst == 3'd0)
          r_a <= alu_r;
        if (r_dst == 3'd1)
          r_x <= alu_r;
        if (r_dst == 3'd2)
          r_y <= alu_r;
        // bit 5 of the status register always reads as one
        if (r_fen)
          r_p <= alu_f | 8'h20;
      end
    end
  end
  assign busy      = r_state != IDLE;
  assign done      = r_done;
  assign mem_rd    = r_state == READ;
  assign mem_wr    = r_state == WRITE_OLD || r_state == WRITE;
  assign mem_addr  = (mem_rd || mem_wr) ? r_addr : '0;
  assign mem_wdata = (r_state == WRITE_OLD) ? r_opnd : (r_state == WRITE) ? r_res : '0;
  assign alu_op    = r_mode;
  assign alu_opc   = r_opc;
  assign alu_p     = r_p;
  assign alu_a     = (r_asel == 2'd1) ? r_x : (r_asel == 2'd2) ? r_y : r_a;
  assign alu_b     = (r_bsel == 2'd0) ? r_a : (r_bsel == 2'd1) ? r_x : (r_bsel == 2'd2) ? r_y : r_opnd;
  assign reg_a     = r_a;
  assign reg_p     = r_p;
endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: random and directed ops against a register/memory reference model, checked by a done-driven scoreboard.
module tb_alu_exec;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  opcode = '0;
  logic [3:0]  alu_mode = '0;
  logic [1:0]  a_sel = '0;
  logic [1:0]  b_sel = '0;
  logic [2:0]  dst_sel = '0;
  logic        flag_en = 1'b0;
  logic [15:0] addr = '0;
  logic        busy, done, mem_rd, mem_wr;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic [3:0]  alu_op;
  logic [7:0]  alu_a, alu_b, alu_p, alu_opc, alu_r, alu_f, reg_a, reg_p;

  alu_exec dut (
    .clock(clock), .reset_n(reset_n), .start(start), .opcode(opcode), .alu_mode(alu_mode),
    .a_sel(a_sel), .b_sel(b_sel), .dst_sel(dst_sel), .flag_en(flag_en), .addr(addr),
    .busy(busy), .done(done), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .alu_op(alu_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_p(alu_p), .alu_opc(alu_opc), .alu_r(alu_r),
    .alu_f(alu_f), .reg_a(reg_a), .reg_p(reg_p)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  p;
    logic [15:0] addr;
    int          nw;
    logic [7:0]  w [2];
  } exp_t;
  typedef struct {
    logic [15:0] addr;
    logic [7:0]  d;
  } wr_t;

  exp_t       sbq[$];
  wr_t        wlog[$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         fixed_lat = -1;
  logic [7:0] tbmem [256];
  logic [7:0] rmem [256];
  logic [7:0] ma = '0, mx = '0, my = '0, mp = 8'h34;

  // 6502-flavoured ALU: flags N V - - - - Z C in the usual bit positions
  function automatic logic [15:0] alu(input logic [3:0] m, input logic [7:0] a, input logic [7:0] b, input logic [7:0] p);
    int s;
    logic [7:0] r;
    logic c, v;
    c = p[0];
    v = p[6];
    s = 0;
    case (m)
      4'd0: r = a | b;
      4'd1: r = a & b;
      4'd2: r = a ^ b;
      4'd3: begin s = int'(a) + int'(b) + int'(p[0]); r = s[7:0]; c = s > 255; v = (a[7] == b[7]) && (r[7] != a[7]); end
      4'd4: begin s = int'(a) + 255 - int'(b) + int'(p[0]); r = s[7:0]; c = s > 255; v = (a[7] != b[7]) && (r[7] != a[7]); end
      4'd6: begin r = a - b; c = a >= b; end
      4'd7: r = a;
      4'd14: r = b - 8'd1;
      4'd15: r = b + 8'd1;
      default: r = b;
    endcase
    return {r[7], v, p[5:2], r == 8'd0, c, r};
  endfunction

  assign {alu_f, alu_r} = alu(alu_op, alu_a, alu_b, alu_p);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic finish_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  endtask

  // memory slave: random or fixed ack latency, plus stray acks while nothing is requested
  int cnt = 0, lat = 0;
  always @(posedge clock) begin
    #1;
    if (mem_ack) begin
      mem_ack = 1'b0;
      cnt = 0;
    end
    mem_rdata = 8'($urandom);
    if (mem_rd || mem_wr) begin
      if (cnt == 0)
        lat = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
      if (cnt == lat) begin
        mem_ack = 1'b1;
        if (mem_rd)
          mem_rdata = tbmem[mem_addr[7:0]];
        else begin
          wlog.push_back('{mem_addr, mem_wdata});
          tbmem[mem_addr[7:0]] = mem_wdata;
        end
      end else
        cnt++;
    end else begin
      cnt = 0;
      mem_ack = $urandom_range(0, 3) == 0;
    end
  end

  exp_t me;
  always @(negedge clock) begin
    if (done) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL done_without_op: got done=1, expected no done at %0t", $time);
      end else begin
        me = sbq.pop_front();
        chk("reg_a", 32'(reg_a), 32'(me.a));
        chk("reg_p", 32'(reg_p), 32'(me.p));
        chk("write_count", wlog.size(), me.nw);
        for (int i = 0; i < me.nw && i < wlog.size(); i++) begin
          chk("write_data", 32'(wlog[i].d), 32'(me.w[i]));
          chk("write_addr", 32'(wlog[i].addr), 32'(me.addr));
        end
        wlog.delete();
      end
    end
  end

  task automatic issue(input logic [3:0] m, input logic [1:0] as, input logic [1:0] bs, input logic [2:0] d,
                       input logic fe, input logic [15:0] ad, input bit garb, input bit wait_it);
    exp_t e;
    logic [7:0] a, b, r, f, opc;
    logic [15:0] rf;
    int cyc;
    a = (as == 2'd1) ? mx : (as == 2'd2) ? my : ma;
    b = (bs == 2'd0) ? ma : (bs == 2'd1) ? mx : (bs == 2'd2) ? my : rmem[ad[7:0]];
    rf = alu(m, a, b, mp);
    r = rf[7:0];
    f = rf[15:8];
    e.nw = 0;
    e.w[0] = '0;
    e.w[1] = '0;
    if (d == 3'd0) ma = r;
    else if (d == 3'd1) mx = r;
    else if (d == 3'd2) my = r;
    else if (d == 3'd3) begin
`ifdef RMW_DUMMY_WRITE_EN
      if (bs == 2'd3) begin
        e.w[e.nw] = b;
        e.nw++;
      end
`endif
      e.w[e.nw] = r;
      e.nw++;
      rmem[ad[7:0]] = r;
    end
    if (fe) mp = f | 8'h20;
    e.a = ma;
    e.p = mp;
    e.addr = ad;
    sbq.push_back(e);
    opc = 8'($urandom);
    opcode = opc;
    alu_mode = m;
    a_sel = as;
    b_sel = bs;
    dst_sel = d;
    flag_en = fe;
    addr = ad;
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    cyc = 1;
    if (wait_it) begin
      while (!done) begin
        if (cyc > 80) begin
          n_cmp++;
          n_err++;
          $display("FAIL done_timeout: got no done after %0d cycles, expected done", cyc);
          finish_run();
        end
        if (garb && $urandom_range(0, 2) == 0) begin
          start = 1'b1;
          opcode = 8'($urandom);
          alu_mode = 4'($urandom);
          a_sel = 2'($urandom);
          b_sel = 2'($urandom);
          dst_sel = 3'($urandom);
          flag_en = 1'($urandom);
          addr = 16'($urandom);
        end
        @(posedge clock);
        #1;
        start = 1'b0;
        cyc++;
      end
      chk("opcode_latch", 32'(alu_opc), 32'(opc));
      if (bs != 2'd3 && d != 3'd3)
        chk("latency", cyc, 2);
    end
  endtask

  logic [7:0] saved;
  initial begin
    for (int i = 0; i < 256; i++) begin
      tbmem[i] = 8'($urandom);
      rmem[i] = tbmem[i];
    end
    repeat (2) @(posedge clock);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_mem_rd", 32'(mem_rd), 0);
    chk("rst_mem_wr", 32'(mem_wr), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_mem_wdata", 32'(mem_wdata), 0);
    chk("rst_reg_a", 32'(reg_a), 0);
    chk("rst_reg_p", 32'(reg_p), 32'h34);
    reset_n = 1'b1;
    tbmem[8'h10] = 8'h50;
    rmem[8'h10] = 8'h50;
    issue(4'd5, 2'd0, 2'd3, 3'd0, 1'b1, 16'h0210, 1'b0, 1'b1);
    issue(4'd3, 2'd0, 2'd3, 3'd0, 1'b1, 16'h0210, 1'b0, 1'b1);
    chk("adc_reg_a", 32'(reg_a), 32'hA0);
    chk("adc_n", 32'(reg_p[7]), 1);
    chk("adc_v", 32'(reg_p[6]), 1);
    chk("adc_c", 32'(reg_p[0]), 0);
    issue(4'd6, 2'd0, 2'd1, 3'd4, 1'b1, 16'h0000, 1'b1, 1'b1);
    chk("cmp_reg_a", 32'(reg_a), 32'hA0);
    chk("cmp_c", 32'(reg_p[0]), 1);
    chk("cmp_n", 32'(reg_p[7]), 1);
    tbmem[8'h00] = 8'hFF;
    rmem[8'h00] = 8'hFF;
    fixed_lat = 3;
    issue(4'd15, 2'd0, 2'd3, 3'd3, 1'b1, 16'h0200, 1'b0, 1'b1);
    fixed_lat = -1;
    chk("inc_mem", 32'(tbmem[8'h00]), 0);
    chk("inc_z", 32'(reg_p[1]), 1);
    for (int n = 0; n < 150; n++)
      issue(4'($urandom), 2'($urandom), 2'($urandom), 3'($urandom), 1'($urandom), {8'h02, 8'($urandom)}, 1'b1, 1'b1);
    saved = rmem[8'h33];
    fixed_lat = 20;
    issue(4'd15, 2'd0, 2'd1, 3'd3, 1'b1, 16'h0233, 1'b0, 1'b0);
    for (int k = 0; k < 10 && !mem_wr; k++) begin
      @(posedge clock);
      #1;
    end
    chk("reached_write", 32'(mem_wr), 1);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b0;
    @(posedge clock);
    #1;
    chk("abort_mem_wr", 32'(mem_wr), 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_reg_p", 32'(reg_p), 32'h34);
    chk("abort_reg_a", 32'(reg_a), 0);
    reset_n = 1'b1;
    sbq.delete();
    wlog.delete();
    rmem[8'h33] = saved;
    ma = '0;
    mx = '0;
    my = '0;
    mp = 8'h34;
    fixed_lat = -1;
    repeat (5) @(posedge clock);
    #1;
    for (int n = 0; n < 30; n++)
      issue(4'($urandom), 2'($urandom), 2'($urandom), 3'($urandom), 1'($urandom), {8'h02, 8'($urandom)}, 1'b1, 1'b1);
    repeat (10) @(posedge clock);
    #1;
    chk("pending_ops", sbq.size(), 0);
    chk("stray_writes", wlog.size(), 0);
    finish_run();
  end
endmodule

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec
Interface
REQ-001 SHALL have parameter P_INIT, default 8'h34, reset value of reg_p.
REQ-002 SHALL have port clock  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset_n  in  1  synchronous, active-low reset.
REQ-004 SHALL have port start  in  1  request; accepted only in IDLE.
REQ-005 SHALL have port opcode  in  8  instruction byte, latched on accept.
REQ-006 SHALL have port alu_mode  in  4  ALU mode code, latched on accept.
REQ-007 SHALL have port a_sel  in  2  ALU A source: 0=A, 1=X, 2=Y, 3=A.
REQ-008 SHALL have port b_sel  in  2  ALU B source: 0=A, 1=X, 2=Y, 3=memory byte.
REQ-009 SHALL have port dst_sel  in  3  destination: 0=A, 1=X, 2=Y, 3=memory, 4..7=none (flags only).
REQ-010 SHALL have port flag_en  in  1  write ALU flags to reg_p.
REQ-011 SHALL have port addr  in  16  memory operand address, latched on accept.
REQ-012 SHALL have port busy  out  1  high whenever state is not IDLE.
REQ-013 SHALL have port done  out  1  one-cycle completion pulse.
REQ-014 SHALL have port mem_addr  out  16  latched addr during READ/WRITE states, else 0.
REQ-015 SHALL have port mem_rd  out  1  read request, high throughout READ.
REQ-016 SHALL have port mem_wr  out  1  write request, high throughout WRITE_OLD/WRITE.
REQ-017 SHALL have port mem_wdata  out  8  write data; 0 when mem_wr low.
REQ-018 SHALL have port mem_rdata  in  8  read data, valid with mem_ack.
REQ-019 SHALL have port mem_ack  in  1  completes current memory request.
REQ-020 SHALL have ports alu_op (out 4), alu_a (out 8), alu_b (out 8), alu_p (out 8), alu_opc (out 8): ALU mode, operands, current reg_p, latched opcode.
REQ-021 SHALL have ports alu_r (in 8), alu_f (in 8): combinational ALU result and flags.
REQ-022 SHALL have ports reg_a (out 8), reg_p (out 8): accumulator and status register.
Function
REQ-023 SHALL implement states IDLE, READ, EXEC, WRITE_OLD, WRITE; outputs decoded from state (Moore), no combinational input-to-output path except alu_* operands from latches.
REQ-024 IDLE: start=1 latches opcode/alu_mode/sels/flag_en/addr; next READ if b_sel=3, else EXEC; start while busy ignored.
REQ-025 READ: hold mem_rd until mem_ack; on ack latch mem_rdata as operand, go EXEC; wait unbounded.
REQ-026 EXEC (exactly one cycle): capture alu_r; write to A/X/Y per dst_sel; if flag_en, reg_p <= alu_f with bit 5 forced 1; dst=memory -> WRITE_OLD (macro) or WRITE, else IDLE.
REQ-027 WRITE_OLD: mem_wdata = unmodified operand until mem_ack, then WRITE; WRITE: mem_wdata = captured result until mem_ack, then IDLE.
REQ-028 done SHALL be registered, high for exactly the one cycle after leaving EXEC-to-IDLE or WRITE-to-IDLE; register updates visible in that same cycle; start accepted in that cycle.
REQ-029 Latency, register-only op: start in cycle 0 -> EXEC cycle 1 -> done cycle 2; each memory phase adds (ack wait + 1) cycles.
REQ-030 mem_ack outside READ/WRITE_OLD/WRITE SHALL be ignored; ack in the first cycle of a request completes it.
REQ-031 alu_p SHALL reflect reg_p at EXEC, so carry-in uses the pre-instruction C flag.
Reset
REQ-032 reset_n low at a clock edge: state IDLE, reg_a/X/Y=0, reg_p=P_INIT, all latches 0, busy/done/mem_rd/mem_wr=0, mem_addr/mem_wdata=0.
REQ-033 Reset mid-operation SHALL abort without done or further memory requests; partial updates already committed stay until reset applies.
Configuration
REQ-034 RMW_DUMMY_WRITE_EN defined: dst=memory with b_sel=3 passes through WRITE_OLD (6502 dummy write); undefined or b_sel!=3: WRITE_OLD never entered, EXEC goes directly to WRITE.
Verification
REQ-035 Reset, P_INIT default -> reg_p=8'h34, reg_a=0, busy=0, done=0, mem_rd=mem_wr=0.
REQ-036 LDA mem (mode 0101, b_sel=3, dst=A, flag_en) rdata 8'h50 ack 1 cycle, then ADC mem (0011) rdata 8'h50 -> reg_a=8'hA0, reg_p[7]=1, [6]=1, [0]=0.
REQ-037 INC mem (1111, b_sel=3, dst=3) addr 16'h0200, rdata 8'hFF, ack after 3 cycles, macro on -> writes 8'hFF then 8'h00 to 16'h0200, Z=1, single done.
REQ-038 Same as REQ-037, macro off -> exactly one write of 8'h00, done 1 cycle after write ack.
REQ-039 CMP (0110, dst=4) reg_a=8'hA0 vs X=0, start re-pulsed while busy -> reg_a unchanged, C=1, N=1, one op only.
REQ-040 reset_n low during WRITE wait -> mem_wr=0 next cycle, no done, reg_p=8'h34.
